alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 150 +++++++++++++++
 tb/tb_alu_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request side and a valid/ready
// result side. Single-cycle ops finish one cycle after accept. MUL is an
// iterative shift-add that takes WIDTH extra cycles. c and flags are
// registered and change only when a new result is produced.
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] c_o,
  output logic [7:0]       flags_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Flag bit positions. Bits 7:5 are never written, so they read as 0.
  localparam int F_EQ  = 0;
  localparam int F_GRT = 1;
  localparam int F_ZER = 2;
  localparam int F_CY  = 3;
  localparam int F_NEG = 4;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] c_q;
  logic [7:0]       flags_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    prod_q;

  logic             accept;
  logic             is_mul;
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] sc_c;
  logic [7:0]       sc_flags;
  logic             sc_cy, sc_upd;
  logic [PW-1:0]    pp, prod_nxt;

  assign accept      = in_valid_i && (state_q == S_IDLE);
  assign is_mul      = MUL_EN && (op_i == 4'd9);
  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign c_o         = c_q;
  assign flags_o     = flags_q;

  // Single-cycle result and flags, evaluated from the live request so that
  // they can be captured at the accept edge. Unknown opcodes fall through to
  // the default: c = a and flags untouched.
  always_comb begin
    add_w    = {1'b0, a_i} + {1'b0, b_i};
    sub_w    = {1'b0, a_i} - {1'b0, b_i};
    sc_c     = a_i;
    sc_flags = flags_q;
    sc_cy    = 1'b0;
    sc_upd   = 1'b0;
    case (op_i)
      4'd0: begin sc_c = add_w[WIDTH-1:0]; sc_cy = add_w[WIDTH]; sc_upd = 1'b1; end
      // The borrow appears as the extension bit of the widened difference.
      4'd1: begin sc_c = sub_w[WIDTH-1:0]; sc_cy = sub_w[WIDTH]; sc_upd = 1'b1; end
      4'd2: begin sc_c = a_i & b_i; sc_upd = 1'b1; end
      4'd3: begin sc_c = a_i | b_i; sc_upd = 1'b1; end
      4'd4: begin sc_c = a_i ^ b_i; sc_upd = 1'b1; end
      4'd5: begin sc_c = ~a_i;      sc_upd = 1'b1; end
      4'd6: begin
        sc_flags[F_EQ]  = (a_i == b_i);
        sc_flags[F_GRT] = (a_i > b_i);
      end
      4'd7: begin
        sc_c   = {a_i[WIDTH-2:0], 1'b0};
        sc_cy  = a_i[WIDTH-1];
        sc_upd = 1'b1;
      end
      4'd8: begin
        sc_c   = {1'b0, a_i[WIDTH-1:1]};
        sc_cy  = a_i[0];
        sc_upd = 1'b1;
      end
      default: ;
    endcase
    if (sc_upd) begin
      sc_flags[F_ZER] = (sc_c == '0);
      sc_flags[F_CY]  = sc_cy;
      sc_flags[F_NEG] = sc_c[WIDTH-1];
    end
  end

  // One shift-add step: add a << cnt when bit cnt of b is set.
  always_comb begin
    pp       = b_q[cnt_q] ? (PW'(a_q) << cnt_q) : '0;
    prod_nxt = prod_q + pp;
  end

  // Control FSM plus the result registers. Reset has priority over both
  // accept and retire.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      flags_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              a_q     <= a_i;
              b_q     <= b_i;
              cnt_q   <= '0;
              prod_q  <= '0;
              state_q <= S_MUL;
            end else begin
              c_q     <= sc_c;
              flags_q <= sc_flags;
              state_q <= S_DONE;
            end
          end
        end
        S_MUL: begin
          prod_q <= prod_nxt;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            c_q            <= prod_nxt[WIDTH-1:0];
            flags_q[F_ZER] <= (prod_nxt[WIDTH-1:0] == '0);
            flags_q[F_CY]  <= (prod_nxt[PW-1:WIDTH] != '0);
            flags_q[F_NEG] <= prod_nxt[WIDTH-1];
            state_q        <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8). An expectation is pushed to a
// scoreboard queue at each accept. It is popped and compared when out_valid
// appears.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready, in_ready, out_valid;
  logic [3:0] op;
  logic [7:0] a, b, c, flags;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .c_o        (c),
    .flags_o    (flags),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready)
  );

  typedef struct {
    logic [7:0] c;
    logic [7:0] f;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mflags;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model. Flags carry over between results exactly as the
  // architectural flags register does.
  task automatic model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                       output exp_t e);
    int         s;
    logic [7:0] r;
    logic       cy;
    bit         arith;
    r = x; cy = 1'b0; arith = 1'b1; e.lat = 1;
    case (o)
      4'd0: begin s = int'(x) + int'(y); r = 8'(s); cy = (s > 255); end
      4'd1: begin r = x - y; cy = (x < y); end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = ~x;
      4'd6: begin arith = 1'b0; mflags[0] = (x == y); mflags[1] = (x > y); end
      4'd7: begin r = 8'(int'(x) * 2); cy = (x >= 8'h80); end
      4'd8: begin r = x / 8'd2; cy = ((x % 8'd2) != 8'd0); end
      4'd9: begin s = int'(x) * int'(y); r = 8'(s); cy = (s > 255); e.lat = 9; end
      default: arith = 1'b0;
    endcase
    if (arith) begin
      mflags[3] = cy;
      mflags[2] = (r == 8'h00);
      mflags[4] = r[7];
    end
    e.c = r;
    e.f = mflags;
  endtask

  // Wait (bounded) for in_ready, then present one request for exactly one
  // accept edge. After that, scramble the inputs to show they are not
  // re-sampled.
  task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("send_ready", in_ready, 1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
    model(o, x, y, e);
    sb.push_back(e);
  endtask

  // Called 1ns after the accept edge. Counts cycles until out_valid appears
  // and checks that the block is busy meanwhile. With poke set, it holds
  // in_valid high during the busy window, and that request must be ignored.
  task automatic get_result(input string tag, input bit poke);
    exp_t e;
    int   lat = 1;
    while (!out_valid && lat < 40) begin
      chk({tag, "_busy_ready"}, in_ready, 0);
      if (poke) begin in_valid = 1'b1; op = 4'd0; end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s_scoreboard: observed empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"},   out_valid, 1);
      chk({tag, "_latency"}, lat,       e.lat);
      chk({tag, "_c"},       c,         e.c);
      chk({tag, "_flags"},   flags,     e.f);
    end
  endtask

  logic [3:0] t_op [10] = '{4'd7,  4'd8,  4'd3,  4'd4,  4'd5,  4'd1,  4'd9,  4'd9,  4'd0,  4'd6};
  logic [7:0] t_a  [10] = '{8'h81, 8'h01, 8'h50, 8'hFF, 8'h0F, 8'h03, 8'hFF, 8'h00, 8'h7F, 8'h05};
  logic [7:0] t_b  [10] = '{8'h00, 8'h00, 8'h0A, 8'h0F, 8'h00, 8'h05, 8'hFF, 8'h37, 8'h01, 8'h05};

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0; mflags = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_c",     c,         0);
    chk("rst_flags", flags,     0);
    chk("rst_valid", out_valid, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", in_ready, 1);

    send(4'd0, 8'hF0, 8'h20); get_result("add_carry", 1'b0);
    chk("add_c_const",     c,     8'h10);
    chk("add_flags_const", flags, 8'h08);
    send(4'd1, 8'h05, 8'h05); get_result("sub_zero", 1'b0);
    send(4'd6, 8'h07, 8'h03); get_result("cmp", 1'b0);
    chk("cmp_flags_const", flags, 8'h06);
    send(4'hC, 8'h5A, 8'h11); get_result("rsvd", 1'b0);
    chk("rsvd_flags_const", flags, 8'h06);
    send(4'd9, 8'h10, 8'h11); get_result("mul", 1'b1);
    chk("mul_c_const", c, 8'h10);
    @(posedge clk); #1;
    chk("mul_retired", out_valid, 0);

    // Backpressure on an AND result.
    out_ready = 1'b0;
    send(4'd2, 8'hCC, 8'hAA); get_result("and_bp", 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_c",     c,         8'h88);
      chk("bp_flags", flags,     8'h12);
      chk("bp_ready", in_ready,  0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", in_ready,  1);
    chk("bp_release_valid", out_valid, 0);

    // Reset in the 4th MUL cycle discards the operation.
    send(4'd9, 8'h03, 8'h05);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mulrst_c",     c,         0);
    chk("mulrst_flags", flags,     0);
    chk("mulrst_valid", out_valid, 0);
    chk("mulrst_ready", in_ready,  1);
    sb.delete(); mflags = '0;
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; seen |= out_valid; end
    chk("mulrst_no_stale", seen, 0);

    for (int i = 0; i < 10; i++) begin
      send(t_op[i], t_a[i], t_b[i]);
      get_result($sformatf("tbl%0d", i), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
